load_unit: RTL and testbench

- Load-side companion to the Store byte-enable block in the LSU.
- Accepts one load request at a time: funct3 plus byte address.
- Performs a word-aligned read on the synchronous data-memory port (req/gnt/rvalid handshake).
- Extracts the addressed byte, halfword or word with sign/zero extension and returns it with the destination register tag.

---
 rtl/load_store_pkg.sv | 45 ++++
 rtl/load_unit_if.sv | 45 ++++
 rtl/load_unit_extract.sv | 39 +++
 rtl/load_unit.sv | 139 +++++++++++++
 tb/tb_load_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_pkg.sv
// Shared load/store definitions: funct3 encodings, load FSM state encoding,
// and access-legality helpers.
package load_store_pkg;

  localparam int OFFSET_W = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_REQ2  = 3'd4,
    S_WAIT2 = 3'd5
  } state_e;

  function automatic logic is_illegal(input logic [2:0] funct3);
    return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [OFFSET_W-1:0] off);
    case (funct3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // True when the access spills into the next word and needs a second read.
  function automatic logic crosses_word(input logic [2:0] funct3,
                                        input logic [OFFSET_W-1:0] off);
    case (funct3)
      F3_LH, F3_LHU: return off == 2'b11;
      F3_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, data-memory and response signals of the load unit.
// master = surrounding pipeline/memory, slave = load_unit.
interface load_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) ();

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [RD_W-1:0]   req_rd;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [RD_W-1:0]   rsp_rd;
  logic              rsp_err;

  modport master (
    output req_valid, req_funct3, req_addr, req_rd,
    input  req_ready,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_data, rsp_rd, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_rd,
    output req_ready,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_data, rsp_rd, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/load_unit_extract.sv
// Selects the addressed byte/halfword/word from a 64-bit read window
// ({upper word, lower word}) and sign/zero-extends it.
module load_extract
  import load_store_pkg::*;
(
  input  logic [63:0]         window,
  input  logic [OFFSET_W-1:0] off,
  input  logic [2:0]          funct3,
  output logic [31:0]         result
);

  logic [31:0] shifted;
  logic [7:0]  unused_window_top;

  // Largest shift is 24 bits, so the top byte of the window never reaches the result.
  assign unused_window_top = window[63:56];

  always_comb begin
    shifted = window[31:0];
    case (off)
      2'd1:    shifted = window[39:8];
      2'd2:    shifted = window[47:16];
      2'd3:    shifted = window[55:24];
      default: shifted = window[31:0];
    endcase
  end

  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result = {24'd0, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result = {16'd0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: one load at a time, word-aligned memory read, byte/half/word extraction.
// Optional macro LOAD_MISALIGN_SPLIT_EN serves misaligned loads (two reads when crossing a word).
//
// state | meaning
// IDLE  | ready for a request
// REQ   | mem_req held until mem_gnt (first/only word)
// WAIT  | waiting for mem_rvalid (first/only word)
// RESP  | rsp_valid held until rsp_ready
// REQ2  | mem_req for the following word (split build only)
// WAIT2 | waiting for the following word (split build only)
module load_unit
  import load_store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input logic       clk,
  input logic       rst_n,
  load_unit_if.slave bus
);

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] REQ   = S_REQ;
  localparam logic [2:0] WAIT  = S_WAIT;
  localparam logic [2:0] RESP  = S_RESP;

  logic [2:0]          state;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [RD_W-1:0]     rd_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic                req_bad;
  logic [ADDR_W-1:0]   base_addr;
  logic [63:0]         window;
  logic [DATA_W-1:0]   ext_data;

  assign base_addr = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam logic [2:0] REQ2  = S_REQ2;
  localparam logic [2:0] WAIT2 = S_WAIT2;

  logic              split_q;
  logic [DATA_W-1:0] lo_q;

  assign req_bad      = is_illegal(bus.req_funct3);
  assign window       = (state == WAIT2) ? {bus.mem_rdata, lo_q} : {32'd0, bus.mem_rdata};
  assign bus.mem_req  = (state == REQ) || (state == REQ2);
  assign bus.mem_addr = (state == REQ)  ? base_addr :
                        (state == REQ2) ? base_addr + ADDR_W'(4) : '0;
`else
  assign req_bad      = is_illegal(bus.req_funct3) ||
                        is_misaligned(bus.req_funct3, bus.req_addr[OFFSET_W-1:0]);
  assign window       = {32'd0, bus.mem_rdata};
  assign bus.mem_req  = (state == REQ);
  assign bus.mem_addr = (state == REQ) ? base_addr : '0;
`endif

  load_extract u_extract (
    .window (window),
    .off    (addr_q[OFFSET_W-1:0]),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_rd    = rd_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      lo_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            rd_q     <= bus.req_rd;
            data_q   <= '0;
            err_q    <= req_bad;
            state    <= req_bad ? RESP : REQ;
`ifdef LOAD_MISALIGN_SPLIT_EN
            split_q  <= crosses_word(bus.req_funct3, bus.req_addr[OFFSET_W-1:0]);
`endif
          end
        end
        REQ: begin
          if (bus.mem_gnt) state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
            if (split_q) begin
              lo_q  <= bus.mem_rdata;
              state <= REQ2;
            end else begin
              data_q <= ext_data;
              state  <= RESP;
            end
`else
            data_q <= ext_data;
            state  <= RESP;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        REQ2: begin
          if (bus.mem_gnt) state <= WAIT2;
        end
        WAIT2: begin
          if (bus.mem_rvalid) begin
            data_q <= ext_data;
            state  <= RESP;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: vector table driven through a small memory
// responder, with a response scoreboard and hand-written reset sequence.
module tb_load_unit;
  import load_store_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_unit_if #(.ADDR_W(32), .DATA_W(32), .RD_W(5)) bus ();

  load_unit #(.ADDR_W(32), .DATA_W(32), .RD_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] w1;
    logic [31:0] w2;
    int          gnt_dly;
    int          rdy_dly;
    logic [31:0] exp_data;
    logic        exp_err;
    int          n_acc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input int gnt_dly, input int rdy_dly,
                              input logic [31:0] exp_data, input logic exp_err, input int n_acc);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.rd = rd; v.w1 = w1; v.w2 = w2;
    v.gnt_dly = gnt_dly; v.rdy_dly = rdy_dly;
    v.exp_data = exp_data; v.exp_err = exp_err; v.n_acc = n_acc;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_rd     = 5'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e, cur;
    int          cyc, gnt_cnt, rdy_cnt, acc, lat;
    bit          rv_pending, seen_rsp, done;
    logic [31:0] exp_maddr;

    lat = v.exp_err ? 1 : 1 + v.n_acc * (2 + v.gnt_dly);
    check($sformatf("v%0d req_ready before", idx), {31'd0, bus.req_ready}, 32'd1);

    bus.req_valid  = 1'b1;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_rd     = v.rd;
    e.data = v.exp_data; e.rd = v.rd; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    idle_inputs();

    cyc = 1; gnt_cnt = 0; rdy_cnt = 0; acc = 0;
    rv_pending = 0; seen_rsp = 0; done = 0;
    cur = e;
    while (!done && cyc < 80) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.rsp_ready = 1'b0;
      bus.mem_rdata = 32'h5A5A_5A5A;
      check($sformatf("v%0d req_ready busy c%0d", idx, cyc), {31'd0, bus.req_ready}, 32'd0);
      if (rv_pending) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = (acc <= 1) ? v.w1 : v.w2;
        rv_pending = 0;
      end
      if (bus.mem_req) begin
        exp_maddr = (v.addr & 32'hFFFF_FFFC) + 32'(4 * acc);
        check($sformatf("v%0d mem_addr c%0d", idx, cyc), bus.mem_addr, exp_maddr);
        if (gnt_cnt == v.gnt_dly) begin
          bus.mem_gnt = 1'b1;
          rv_pending = 1;
          acc++;
          gnt_cnt = 0;
        end else begin
          gnt_cnt++;
        end
      end
      if (bus.rsp_valid) begin
        if (!seen_rsp) begin
          seen_rsp = 1;
          check($sformatf("v%0d latency", idx), 32'(cyc), 32'(lat));
          if (sb.size() > 0) begin
            cur = sb.pop_front();
          end else begin
            check($sformatf("v%0d scoreboard depth", idx), 32'(sb.size()), 32'd1);
          end
        end
        check($sformatf("v%0d rsp_data c%0d", idx, cyc), bus.rsp_data, cur.data);
        check($sformatf("v%0d rsp_rd c%0d", idx, cyc), {27'd0, bus.rsp_rd}, {27'd0, cur.rd});
        check($sformatf("v%0d rsp_err c%0d", idx, cyc), {31'd0, bus.rsp_err}, {31'd0, cur.err});
        if (rdy_cnt == v.rdy_dly) begin
          bus.rsp_ready = 1'b1;
          done = 1;
        end else begin
          rdy_cnt++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    check($sformatf("v%0d completed", idx), {31'd0, done}, 32'd1);
    check($sformatf("v%0d memory accesses", idx), 32'(acc), 32'(v.n_acc));
    check($sformatf("v%0d req_ready after", idx), {31'd0, bus.req_ready}, 32'd1);
    check($sformatf("v%0d rsp_valid after", idx), {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, " mem_req"},   {31'd0, bus.mem_req},   32'd0);
    check({tag, " mem_addr"},  bus.mem_addr,           32'd0);
    check({tag, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, " rsp_data"},  bus.rsp_data,           32'd0);
    check({tag, " rsp_rd"},    {27'd0, bus.rsp_rd},    32'd0);
    check({tag, " rsp_err"},   {31'd0, bus.rsp_err},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    vecs.push_back(mk(F3_LB,  32'h0000_1003, 5'd5,  32'h80FF_1234, 32'h0, 0, 0, 32'hFFFF_FF80, 1'b0, 1));
    vecs.push_back(mk(F3_LHU, 32'h0000_1002, 5'd6,  32'h8001_0000, 32'h0, 0, 0, 32'h0000_8001, 1'b0, 1));
    vecs.push_back(mk(F3_LH,  32'h0000_1002, 5'd7,  32'h8001_0000, 32'h0, 0, 0, 32'hFFFF_8001, 1'b0, 1));
    vecs.push_back(mk(F3_LBU, 32'h0000_1001, 5'd8,  32'h80FF_1234, 32'h0, 0, 0, 32'h0000_0012, 1'b0, 1));
    vecs.push_back(mk(F3_LB,  32'h0000_1002, 5'd9,  32'h80FF_1234, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1));
    vecs.push_back(mk(F3_LBU, 32'h0000_1000, 5'd10, 32'h80FF_1234, 32'h0, 0, 0, 32'h0000_0034, 1'b0, 1));
    vecs.push_back(mk(F3_LH,  32'h0000_2000, 5'd11, 32'h1234_8765, 32'h0, 0, 0, 32'hFFFF_8765, 1'b0, 1));
    vecs.push_back(mk(F3_LHU, 32'h0000_2000, 5'd12, 32'h1234_8765, 32'h0, 0, 0, 32'h0000_8765, 1'b0, 1));
    vecs.push_back(mk(F3_LW,  32'h0000_1004, 5'd13, 32'hDEAD_BEEF, 32'h0, 3, 2, 32'hDEAD_BEEF, 1'b0, 1));
    vecs.push_back(mk(F3_LB,  32'h0000_2005, 5'd14, 32'h0000_7F00, 32'h0, 1, 1, 32'h0000_007F, 1'b0, 1));
    vecs.push_back(mk(3'b011, 32'h0000_1000, 5'd15, 32'h1111_1111, 32'h0, 0, 0, 32'h0,         1'b1, 0));
    vecs.push_back(mk(3'b110, 32'h0000_1004, 5'd16, 32'h1111_1111, 32'h0, 0, 1, 32'h0,         1'b1, 0));
    vecs.push_back(mk(3'b111, 32'h0000_1008, 5'd17, 32'h1111_1111, 32'h0, 0, 0, 32'h0,         1'b1, 0));
`ifdef LOAD_MISALIGN_SPLIT_EN
    vecs.push_back(mk(F3_LW,  32'h0000_1002, 5'd18, 32'h4433_2211, 32'h8877_6655, 0, 0, 32'h6655_4433, 1'b0, 2));
    vecs.push_back(mk(F3_LH,  32'h0000_1001, 5'd19, 32'h80FF_1234, 32'h0,         0, 0, 32'hFFFF_FF12, 1'b0, 1));
    vecs.push_back(mk(F3_LW,  32'hFFFF_FFFE, 5'd20, 32'hBBBB_AAAA, 32'hDDDD_CCCC, 0, 0, 32'hCCCC_BBBB, 1'b0, 2));
    vecs.push_back(mk(F3_LHU, 32'h0000_1003, 5'd21, 32'h1122_3344, 32'h5566_7788, 0, 0, 32'h0000_8811, 1'b0, 2));
    vecs.push_back(mk(F3_LW,  32'h0000_1001, 5'd22, 32'h4433_2211, 32'h8877_6655, 1, 0, 32'h5544_3322, 1'b0, 2));
`else
    vecs.push_back(mk(F3_LW,  32'h0000_1002, 5'd18, 32'h4433_2211, 32'h0, 0, 0, 32'h0, 1'b1, 0));
    vecs.push_back(mk(F3_LH,  32'h0000_1001, 5'd19, 32'h80FF_1234, 32'h0, 0, 0, 32'h0, 1'b1, 0));
    vecs.push_back(mk(F3_LW,  32'hFFFF_FFFE, 5'd20, 32'hBBBB_AAAA, 32'h0, 0, 0, 32'h0, 1'b1, 0));
    vecs.push_back(mk(F3_LHU, 32'h0000_1003, 5'd21, 32'h1122_3344, 32'h0, 0, 0, 32'h0, 1'b1, 0));
    vecs.push_back(mk(F3_LHU, 32'h0000_1001, 5'd22, 32'h1122_3344, 32'h0, 0, 0, 32'h0, 1'b1, 0));
`endif

    repeat (3) @(posedge clk);
    #1;
    check_quiet("in reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_quiet("after reset");

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    bus.req_valid  = 1'b1;
    bus.req_funct3 = F3_LW;
    bus.req_addr   = 32'h0000_3000;
    bus.req_rd     = 5'd9;
    @(posedge clk); #1;
    idle_inputs();
    check("rst seq mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("rst seq mem_addr", bus.mem_addr, 32'h0000_3000);
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    check("rst seq wait mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst seq wait req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    check("rst seq async req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_quiet($sformatf("rst seq post c%0d", k));
      @(posedge clk); #1;
    end

    // Unit still works after the abandoned transaction.
    run_vec(mk(F3_LBU, 32'h0000_4003, 5'd3, 32'hA5C3_0000, 32'h0, 0, 0, 32'h0000_00A5, 1'b0, 1), 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
